// File: rtl/inst_fetch_unit_if.sv
// AXI4-Lite read-channel bundle between the instruction fetch unit (master)
// and instruction memory / crossbar (slave). Only AR and R are needed.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: accepts a PC from the PC unit, reads the 32-bit
// instruction over AXI4-Lite (one read outstanding), and hands instruction
// plus PC to decode over valid/ready. A flush during an in-flight read lets
// the AXI transaction finish but discards its data.
//
// Optional feature macro: IFU_FAULT_CHECK_EN
//   defined   -> misaligned PC faults without a bus access, and a non-OKAY
//                rresp returns inst=0 with inst_fault=1.
//   undefined -> inst_fault is always 0, rresp is ignored, misaligned PCs
//                are fetched as-is.
// DATA_W must stay 32; the parameter exists only for interface symmetry.
module inst_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    inst_fetch_unit_if.master axi,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              inst_fault
);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        OUT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              fault_q, fault_d;
    logic              drop_q, drop_d;

`ifndef IFU_FAULT_CHECK_EN
    // Response code is deliberately ignored in this build.
    logic [1:0] rresp_unused;
    assign rresp_unused = axi.rresp;
`endif

    // Next-state and next-register-value logic for the fetch sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path can leave
        // it unassigned; otherwise synthesis would infer a latch.
        state_d      = state_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        drop_d       = drop_q;

        unique case (state_q)
            IDLE: begin
                // A flush here is harmless: the pc offered alongside it is
                // the redirect target and is accepted normally.
                if (pc_valid) begin
`ifdef IFU_FAULT_CHECK_EN
                    if (pc[1:0] != 2'b00) begin
                        inst_d       = '0;
                        inst_pc_d    = pc;
                        fault_d      = 1'b1;
                        inst_valid_d = 1'b1;
                        state_d      = OUT;
                    end else begin
                        araddr_d  = pc;
                        arvalid_d = 1'b1;
                        state_d   = AR;
                    end
`else
                    araddr_d  = pc;
                    arvalid_d = 1'b1;
                    state_d   = AR;
`endif
                end
            end

            AR: begin
                // arvalid is never withdrawn; a flush only marks the result.
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (arvalid_q && axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end

            R: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (axi.rvalid && rready_q) begin
                    rready_d = 1'b0;
                    // A flush coinciding with the data beat also discards it.
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        inst_pc_d    = araddr_q;
                        inst_valid_d = 1'b1;
                        state_d      = OUT;
`ifdef IFU_FAULT_CHECK_EN
                        if (axi.rresp != 2'b00) begin
                            inst_d  = '0;
                            fault_d = 1'b1;
                        end else begin
                            inst_d  = axi.rdata;
                            fault_d = 1'b0;
                        end
`else
                        inst_d = axi.rdata;
`endif
                    end
                end
            end

            OUT: begin
                // Flush wins over a simultaneous inst_ready: not delivered.
                if (flush || inst_ready) begin
                    inst_valid_d = 1'b0;
                    fault_d      = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values computed above, independent of statement order.
        if (rst) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
            drop_q       <= drop_d;
        end
    end

    assign pc_ready    = (state_q == IDLE);
    assign axi.araddr  = araddr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = inst_valid_q;
    assign inst_fault  = fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        inst_fault;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    inst_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .flush      (flush),
        .axi        (bus.master),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_fault (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        pc          = '0;
        pc_valid    = 1'b0;
        flush       = 1'b0;
        inst_ready  = 1'b0;
        bus.arready = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rvalid  = 1'b0;

        // Reset state
        step();
        step();
        check("rst_arvalid", 32'(bus.arvalid), 0);
        check("rst_araddr", bus.araddr, 0);
        check("rst_rready", 32'(bus.rready), 0);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst_fault", 32'(inst_fault), 0);
        check("rst_pc_ready", 32'(pc_ready), 1);
        rst = 1'b0;

        // Basic fetch: zero-wait AXI, inst_valid in cycle 3
        pc          = 32'h8000_0000;
        pc_valid    = 1'b1;
        bus.arready = 1'b1;
        step();
        cyc      = 1;
        pc_valid = 1'b0;
        check("b_arvalid", 32'(bus.arvalid), 1);
        check("b_araddr", bus.araddr, 32'h8000_0000);
        check("b_pc_ready", 32'(pc_ready), 0);
        step();
        check("b_rready", 32'(bus.rready), 1);
        check("b_arvalid_low", 32'(bus.arvalid), 0);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0000_0413;
        step();
        bus.rvalid = 1'b0;
        check("b_inst_valid", 32'(inst_valid), 1);
        check("b_latency", cyc, 3);
        check("b_inst", inst, 32'h0000_0413);
        check("b_inst_pc", inst_pc, 32'h8000_0000);
        check("b_rready_low", 32'(bus.rready), 0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("b_accept_valid", 32'(inst_valid), 0);
        check("b_accept_pc_ready", 32'(pc_ready), 1);

        // AR backpressure (5 cycles) followed by a 4-cycle decode stall
        pc          = 32'h8000_0004;
        pc_valid    = 1'b1;
        bus.arready = 1'b0;
        step();
        cyc      = 1;
        pc_valid = 1'b0;
        pc       = 32'h0;
        for (int i = 0; i < 5; i++) begin
            check("bp_arvalid", 32'(bus.arvalid), 1);
            check("bp_araddr", bus.araddr, 32'h8000_0004);
            step();
        end
        check("bp_arvalid_end", 32'(bus.arvalid), 1);
        bus.arready = 1'b1;
        step();
        check("bp_rready", 32'(bus.rready), 1);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0040_0093;
        step();
        bus.rvalid = 1'b0;
        check("bp_latency", cyc, 8);
        check("bp_inst_valid", 32'(inst_valid), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("st_inst_valid", 32'(inst_valid), 1);
            check("st_inst", inst, 32'h0040_0093);
            check("st_inst_pc", inst_pc, 32'h8000_0004);
            check("st_pc_ready", 32'(pc_ready), 0);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("st_accept_valid", 32'(inst_valid), 0);
        check("st_accept_pc_ready", 32'(pc_ready), 1);

        // Flush while waiting in R: data discarded, next pc fetched normally
        pc       = 32'h8000_0008;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        check("fr_rready", 32'(bus.rready), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hDEAD_BEEF;
        step();
        bus.rvalid = 1'b0;
        check("fr_no_valid", 32'(inst_valid), 0);
        check("fr_idle", 32'(pc_ready), 1);
        check("fr_rready_low", 32'(bus.rready), 0);
        step();
        check("fr_still_no_valid", 32'(inst_valid), 0);
        pc       = 32'h8000_0100;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        check("fr_next_araddr", bus.araddr, 32'h8000_0100);
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0010_0093;
        step();
        bus.rvalid = 1'b0;
        check("fr_next_valid", 32'(inst_valid), 1);
        check("fr_next_inst", inst, 32'h0010_0093);
        check("fr_next_inst_pc", inst_pc, 32'h8000_0100);

        // Flush in OUT with simultaneous inst_ready: not delivered
        flush      = 1'b1;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("fo_valid_drop", 32'(inst_valid), 0);
        check("fo_idle", 32'(pc_ready), 1);

        // Flush in IDLE together with pc_valid: pc accepted
        pc       = 32'h8000_0200;
        pc_valid = 1'b1;
        step();
        flush    = 1'b0;
        pc_valid = 1'b0;
        check("fi_arvalid", 32'(bus.arvalid), 1);
        check("fi_araddr", bus.araddr, 32'h8000_0200);
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0000_0013;
        step();
        bus.rvalid = 1'b0;
        check("fi_inst", inst, 32'h0000_0013);
        check("fi_inst_pc", inst_pc, 32'h8000_0200);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("fi_accept", 32'(inst_valid), 0);

        // Reset in the middle of a fetch; a late rvalid is ignored
        pc       = 32'h8000_0300;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_rready", 32'(bus.rready), 0);
        check("mr_idle", 32'(pc_ready), 1);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1111_1111;
        step();
        bus.rvalid = 1'b0;
        check("mr_late_rvalid", 32'(inst_valid), 0);
        check("mr_inst", inst, 0);

`ifdef IFU_FAULT_CHECK_EN
        // Misaligned pc: no bus access, fault reported directly
        pc       = 32'h8000_0002;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        check("fm_arvalid", 32'(bus.arvalid), 0);
        check("fm_inst_valid", 32'(inst_valid), 1);
        check("fm_fault", 32'(inst_fault), 1);
        check("fm_inst", inst, 0);
        check("fm_inst_pc", inst_pc, 32'h8000_0002);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("fm_fault_clear", 32'(inst_fault), 0);

        // Error response on an aligned fetch
        pc       = 32'h8000_0010;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234_5678;
        bus.rresp  = 2'b10;
        step();
        bus.rvalid = 1'b0;
        bus.rresp  = 2'b00;
        check("fe_fault", 32'(inst_fault), 1);
        check("fe_inst", inst, 0);
        check("fe_inst_pc", inst_pc, 32'h8000_0010);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fe_fault_flushed", 32'(inst_fault), 0);
`else
        // Without fault checking: misaligned pc fetched as-is, rresp ignored
        pc       = 32'h8000_0002;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        check("nm_arvalid", 32'(bus.arvalid), 1);
        check("nm_araddr", bus.araddr, 32'h8000_0002);
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234_5678;
        bus.rresp  = 2'b10;
        step();
        bus.rvalid = 1'b0;
        bus.rresp  = 2'b00;
        check("nm_inst", inst, 32'h1234_5678);
        check("nm_inst_pc", inst_pc, 32'h8000_0002);
        check("nm_fault", 32'(inst_fault), 0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("nm_accept", 32'(inst_valid), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
